// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: header bytes, frame size,
// timeout default and the FSM state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] WR_CMD_DEF     = 8'h55;
    localparam logic [7:0] RD_CMD_DEF     = 8'hAA;
    localparam int         DATA_BYTES_DEF = 4;
    localparam int         TIMEOUT_DEF    = 50000;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_WDATA = 1'b1;

endpackage

// File: rtl/uart_cmd_decode_if.sv
// Byte-stream in, FIFO push and SDRAM request handshakes out of the decoder.
interface uart_cmd_decode_if;

    // rx_flag qualifies rx_data for exactly one cycle and cannot be stalled.
    // wfifo_wr_en qualifies wfifo_data for one cycle; the FIFO never refuses.
    // wr_req/rd_req stay high until the matching *_ack is seen for one cycle.
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic        wfifo_wr_en;
    logic [15:0] wfifo_data;
    logic        wr_req;
    logic        wr_ack;
    logic        rd_req;
    logic        rd_ack;
    logic        frame_err;

    modport master (
        output rx_data, rx_flag, wr_ack, rd_ack,
        input  wfifo_wr_en, wfifo_data, wr_req, rd_req, frame_err
    );

    modport slave (
        input  rx_data, rx_flag, wr_ack, rd_ack,
        output wfifo_wr_en, wfifo_data, wr_req, rd_req, frame_err
    );

endinterface

// File: rtl/uart_cmd_decode_req_hold.sv
// Sticky request flag: set wins over a coincident ack, ack alone clears it.
module req_hold (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic ack,
    output logic req
);

    logic req_q;
    logic req_d;

    always_comb begin
        req_d = set | (req_q & ~ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= 1'b0;
        else        req_q <= req_d;
    end

    assign req = req_q;

endmodule

// File: rtl/uart_cmd_decode.sv
// Parses write frames and read commands from the UART byte stream, packs
// payload bytes into 16-bit FIFO words and raises SDRAM requests.
module uart_cmd_decode
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] WR_CMD     = WR_CMD_DEF,
    parameter logic [7:0] RD_CMD     = RD_CMD_DEF,
    parameter int         DATA_BYTES = DATA_BYTES_DEF,
    parameter int         TIMEOUT    = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_cmd_decode_if.slave bus,
    output state_t       state_o
);

    localparam int             TW        = $clog2(TIMEOUT);
    // Expiry is detected one count early so frame_err lands TIMEOUT cycles after the last byte.
    localparam logic [TW-1:0]  T_LAST    = TW'(TIMEOUT - 2);
    localparam logic [7:0]     LAST_BYTE = 8'(DATA_BYTES - 1);

    state_t         state_q, state_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [7:0]     hi_q, hi_d;
    logic           wr_en_q, wr_en_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           ferr_q, ferr_d;
    logic           wr_set;
    logic           rd_set;
    logic           wr_req;
    logic           rd_req;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        hi_d    = hi_q;
        wr_en_d = 1'b0;
        wdata_d = wdata_q;
        ferr_d  = 1'b0;
        wr_set  = 1'b0;
        rd_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_flag) begin
                    tcnt_d = '0;
                    if (bus.rx_data == WR_CMD) begin
                        state_d = ST_WDATA;
                        bcnt_d  = '0;
                    end else if (bus.rx_data == RD_CMD) begin
                        rd_set = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (bus.rx_flag) begin
                    tcnt_d = '0;
                    bcnt_d = bcnt_q + 8'd1;
                    // bcnt_q counts bytes already taken, so even values mean an odd position.
                    if (!bcnt_q[0]) begin
                        hi_d = bus.rx_data;
                    end else begin
                        wr_en_d = 1'b1;
                        wdata_d = {hi_q, bus.rx_data};
                    end
                    if (bcnt_q == LAST_BYTE) begin
                        wr_set  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tcnt_q == T_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                    hi_d    = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            hi_q    <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            hi_q    <= hi_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            ferr_q  <= ferr_d;
        end
    end

    req_hold u_wr_req (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (wr_set),
        .ack   (bus.wr_ack),
        .req   (wr_req)
    );

    req_hold u_rd_req (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (rd_set),
        .ack   (bus.rd_ack),
        .req   (rd_req)
    );

    assign bus.wfifo_wr_en = wr_en_q;
    assign bus.wfifo_data  = wdata_q;
    assign bus.frame_err   = ferr_q;
    assign bus.wr_req      = wr_req;
    assign bus.rd_req      = rd_req;
    assign state_o         = state_q;

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Directed bench: dut_a uses the default timeout, dut_b a 20-cycle timeout
// for the frame-abort cases.
module tb_uart_cmd_decode;
    import uart_cmd_pkg::*;

    localparam int T_B = 20;

    logic clk;
    logic rst_n;
    int   cyc;

    uart_cmd_decode_if bus_a ();
    uart_cmd_decode_if bus_b ();
    state_t state_a;
    state_t state_b;

    uart_cmd_decode #(.DATA_BYTES(4)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_a),
        .state_o (state_a)
    );

    uart_cmd_decode #(.DATA_BYTES(4), .TIMEOUT(T_B)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_b),
        .state_o (state_b)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_qa[$];
    logic [15:0] exp_qb[$];
    int push_cnt_a = 0;
    int push_cnt_b = 0;
    int ferr_cnt_a = 0;
    int ferr_cnt_b = 0;
    int last_push_a = 0;
    int prev_push_a = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // output monitor, sampled 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (bus_a.wfifo_wr_en) begin
            push_cnt_a++;
            prev_push_a = last_push_a;
            last_push_a = cyc;
            if (exp_qa.size() > 0) check("wdata_a", {16'h0, bus_a.wfifo_data}, {16'h0, exp_qa.pop_front()});
        end
        if (bus_b.wfifo_wr_en) begin
            push_cnt_b++;
            if (exp_qb.size() > 0) check("wdata_b", {16'h0, bus_b.wfifo_data}, {16'h0, exp_qb.pop_front()});
        end
        if (bus_a.frame_err) ferr_cnt_a++;
        if (bus_b.frame_err) ferr_cnt_b++;
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin bus_a.rx_data = d; bus_a.rx_flag = 1'b1; end
        else          begin bus_b.rx_data = d; bus_b.rx_flag = 1'b1; end
        @(negedge clk);
        bus_a.rx_flag = 1'b0;
        bus_b.rx_flag = 1'b0;
    endtask

    logic [7:0] burst_q[$];
    task automatic burst_a();
        @(negedge clk);
        bus_a.rx_flag = 1'b1;
        foreach (burst_q[i]) begin
            bus_a.rx_data = burst_q[i];
            @(negedge clk);
        end
        bus_a.rx_flag = 1'b0;
    endtask

    task automatic ack(input int sel, input bit rd);
        @(negedge clk);
        if (sel == 0) begin if (rd) bus_a.rd_ack = 1'b1; else bus_a.wr_ack = 1'b1; end
        else          begin if (rd) bus_b.rd_ack = 1'b1; else bus_b.wr_ack = 1'b1; end
        @(negedge clk);
        bus_a.rd_ack = 1'b0; bus_a.wr_ack = 1'b0;
        bus_b.rd_ack = 1'b0; bus_b.wr_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fk;
        int pc;
        cyc = 0;
        rst_n = 1'b0;
        bus_a.rx_data = '0; bus_a.rx_flag = 1'b0; bus_a.wr_ack = 1'b0; bus_a.rd_ack = 1'b0;
        bus_b.rx_data = '0; bus_b.rx_flag = 1'b0; bus_b.wr_ack = 1'b0; bus_b.rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",  bus_a.wfifo_wr_en, 0);
        check("rst_wdata",  bus_a.wfifo_data, 0);
        check("rst_wr_req", bus_a.wr_req, 0);
        check("rst_rd_req", bus_a.rd_req, 0);
        check("rst_ferr",   bus_a.frame_err, 0);
        check("rst_state",  state_a, ST_IDLE);
        rst_n = 1'b1;
        idle(2);

        // write frame, bytes 100 cycles apart
        exp_qa.push_back(16'h1122);
        exp_qa.push_back(16'h3344);
        send(0, 8'h55); idle(100);
        send(0, 8'h11); idle(100);
        send(0, 8'h22); idle(100);
        send(0, 8'h33); idle(100);
        check("wr_req_early", bus_a.wr_req, 0);
        send(0, 8'h44);
        check("wr_req_set",   bus_a.wr_req, 1);
        check("t1_pushes",    push_cnt_a, 2);
        check("t1_state",     state_a, ST_IDLE);
        ack(0, 1'b0);
        check("wr_req_clr",   bus_a.wr_req, 0);

        // read commands and ack/set collision
        send(0, 8'hAA);
        check("rd_req_set",   bus_a.rd_req, 1);
        check("t2_nopush",    push_cnt_a, 2);
        send(0, 8'hAA);
        check("rd_req_hold",  bus_a.rd_req, 1);
        @(negedge clk);
        bus_a.rx_data = 8'hAA; bus_a.rx_flag = 1'b1; bus_a.rd_ack = 1'b1;
        @(negedge clk);
        bus_a.rx_flag = 1'b0; bus_a.rd_ack = 1'b0;
        check("rd_set_wins",  bus_a.rd_req, 1);
        ack(0, 1'b1);
        check("rd_req_clr",   bus_a.rd_req, 0);

        // junk byte then headers used as payload
        exp_qa.push_back(16'hAA55);
        exp_qa.push_back(16'h0102);
        send(0, 8'h12); idle(3);
        check("junk_ignored", push_cnt_a, 2);
        send(0, 8'h55); idle(3);
        send(0, 8'hAA); idle(3);
        send(0, 8'h55); idle(3);
        send(0, 8'h01); idle(3);
        send(0, 8'h02);
        check("t3_pushes",    push_cnt_a, 4);
        check("t3_wr_req",    bus_a.wr_req, 1);
        check("t3_rd_req",    bus_a.rd_req, 0);
        ack(0, 1'b0);

        // back-to-back strobes
        exp_qa.push_back(16'h0102);
        exp_qa.push_back(16'h0304);
        burst_q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
        burst_a();
        check("b2b_pushes",   push_cnt_a, 6);
        check("b2b_spacing",  last_push_a - prev_push_a, 2);
        check("b2b_wr_req",   bus_a.wr_req, 1);
        ack(0, 1'b0);

        // timeout abort on dut_b
        exp_qb.push_back(16'h1122);
        send(1, 8'h55); idle(3);
        send(1, 8'h11); idle(3);
        send(1, 8'h22); idle(3);
        send(1, 8'h33);
        fk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_b.frame_err) begin
                fk = k;
                break;
            end
        end
        check("ferr_delay",   fk, T_B - 1);
        check("ferr_state",   state_b, ST_IDLE);
        check("ferr_no_wreq", bus_b.wr_req, 0);
        @(posedge clk);
        #1;
        check("ferr_pulse",   bus_b.frame_err, 0);
        send(1, 8'hAA);
        check("to_rd_req",    bus_b.rd_req, 1);
        check("to_pushes",    push_cnt_b, 1);
        check("to_ferr_cnt",  ferr_cnt_b, 1);

        // strobe landing exactly on the expiry cycle is data
        exp_qb.push_back(16'h0102);
        exp_qb.push_back(16'h0304);
        send(1, 8'h55);
        send(1, 8'h01);
        idle(T_B - 3);
        send(1, 8'h02);
        send(1, 8'h03);
        send(1, 8'h04);
        check("exp_edge_ferr", ferr_cnt_b, 1);
        check("exp_edge_push", push_cnt_b, 3);
        check("exp_edge_wreq", bus_b.wr_req, 1);

        // reset in the middle of a frame
        send(0, 8'hAA);
        send(0, 8'h55);
        send(0, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_req", bus_a.rd_req, 0);
        check("mid_rst_state",  state_a, ST_IDLE);
        check("mid_rst_wr_en",  bus_a.wfifo_wr_en, 0);
        check("mid_rst_wdata",  bus_a.wfifo_data, 0);
        check("mid_rst_wreq_b", bus_b.wr_req, 0);
        idle(2);
        rst_n = 1'b1;
        pc = push_cnt_a;
        send(0, 8'h22);
        send(0, 8'h33);
        idle(2);
        check("post_rst_nopush", push_cnt_a, pc);
        check("post_rst_state",  state_a, ST_IDLE);

        check("exp_qa_empty", exp_qa.size(), 0);
        check("exp_qb_empty", exp_qb.size(), 0);
        check("ferr_a_none",  ferr_cnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decode.md
# uart_cmd_decode

Byte-stream command parser between the UART receiver and the SDRAM write path. It takes the receiver's byte strobe and recognises write frames and read commands. For write frames it packs payload bytes into 16-bit words and pushes them into the SDRAM write FIFO. It raises held write/read requests toward the SDRAM controller until acknowledged.

## Interface
- `WR_CMD`, 8'h55: header byte for a write frame.
- `RD_CMD`, 8'hAA: header byte for a read command.
- `DATA_BYTES`, 4: payload bytes per write frame; even, 2..254.
- `TIMEOUT`, 50000: inter-byte timeout in clk cycles (1 ms at 50 MHz); ≥ 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid when `rx_flag` = 1.
- `rx_flag`  in  1  one-cycle byte-valid strobe.
- `wfifo_wr_en`  out  1  one-cycle push strobe to the write FIFO.
- `wfifo_data`  out  16  pushed word: first byte in [15:8], second in [7:0].
- `wr_req`  out  1  write-burst request, held until acknowledged.
- `wr_ack`  in  1  controller accepted `wr_req`.
- `rd_req`  out  1  read-burst request, held until acknowledged.
- `rd_ack`  in  1  controller accepted `rd_req`.
- `frame_err`  out  1  one-cycle pulse on frame abort by timeout.

One clock. Reset is asynchronous and active-low: `clk`, `rst_n`.

## Operation
- FSM states: IDLE and WDATA.
- IDLE, `rx_flag` with `rx_data` = `WR_CMD`:
  - go to WDATA;
  - clear byte counter;
  - restart timeout counter.
- IDLE, `rx_flag` with `rx_data` = `RD_CMD`:
  - set `rd_req`;
  - stay in IDLE.
- IDLE, any other byte: ignored, no output activity.
- WDATA, each `rx_flag`:
  - byte counter increments;
  - odd-position byte (1st, 3rd, …) is latched into a high-byte register;
  - even-position byte pushes {high, `rx_data`} with `wfifo_wr_en`.
- WDATA, on the `DATA_BYTES`-th byte:
  - push final word;
  - set `wr_req`;
  - return to IDLE.
- Timeout counter:
  - cleared on every `rx_flag`;
  - increments in WDATA only;
  - when it reaches `TIMEOUT`-1 with no strobe: pulse `frame_err`, return to IDLE.
  - Words already pushed stay in the FIFO; the half-assembled high byte is discarded; `wr_req` is not set.
- Request regs (`wr_req`, `rd_req`, each independent):
  - set event and ack in the same cycle → req stays 1;
  - ack with no set → clear;
  - set while already 1 → stays 1; requests do not queue.
- Header bytes are never interpreted inside WDATA; `WR_CMD`/`RD_CMD` values there are data.
- Counter widths: byte counter 8 bits; timeout counter $clog2(`TIMEOUT`) bits.

## Timing
- All outputs are registered.
- Reset values: `wfifo_wr_en`=0, `wfifo_data`=16'h0000, `wr_req`=0, `rd_req`=0, `frame_err`=0; FSM=IDLE; counters and high-byte register 0.
- Strobe at cycle n → `wfifo_wr_en`/`wfifo_data` valid at n+1, for one cycle.
- Final payload strobe at cycle n → `wr_req` rises at n+1, together with the last push.
- `RD_CMD` strobe at cycle n → `rd_req` rises at n+1.
- `*_ack` at cycle m with no coincident set → `*_req` low at m+1.
- Last strobe at cycle n with no further strobe → `frame_err` at cycle n+`TIMEOUT`, FSM in IDLE the same cycle. A strobe arriving exactly at the expiry cycle wins: it is consumed as data and no error is raised.
- `rx_flag` may assert every cycle; no back-pressure. The FIFO is sized by the integrator so it never overflows.
- Reset mid-frame: immediate return to reset values; no push, no request.

## Structure
- Shared package `uart_cmd_pkg`:
  - `WR_CMD`/`RD_CMD` defaults;
  - FSM state encoding;
  - default `TIMEOUT`.
- Request set/hold/clear logic is identical for write and read; implement it as sub-module `req_hold` with ports `clk`, `rst_n`, `set`, `ack`, `req`, instantiated twice.
- No other sub-modules; FSM, counters and packer live in the top module.

## Test plan
- Bytes 55,11,22,33,44 spaced 100 cycles → pushes 16'h1122 then 16'h3344; `wr_req`=1 one cycle after byte 44; `wr_ack` pulse → `wr_req`=0 next cycle.
- Byte AA → `rd_req`=1 next cycle, no pushes. Second AA before `rd_ack` → `rd_req` stays 1. `rd_ack` coincident with a new AA strobe's set cycle → `rd_req` remains 1.
- Byte 12, then 55,AA,55,01,02 → 12 ignored; pushes 16'hAA55, 16'h0102; `wr_req`=1; `rd_req` stays 0.
- `TIMEOUT`=20: bytes 55,11,22,33 then silence → one push 16'h1122; `frame_err` exactly 20 cycles after byte 33; `wr_req`=0. Then AA → `rd_req`=1.
- Back-to-back strobes every cycle: 55,01,02,03,04 → pushes on consecutive-pair cycles, values 16'h0102 and 16'h0304.
- Assert `rst_n`=0 after 55,11 → all outputs 0. After release, 22,33 → no push (FSM in IDLE).
